// File: rtl/dp_seq_pkg.sv
// Shared types and defaults for the datapath operand sequencer.
package dp_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Default operand width and the matching x-result width
  localparam int DATAWIDTH_DEF = 8;
  localparam int XWIDTH        = 2 * DATAWIDTH_DEF;

endpackage

// File: rtl/dp_operand_sequencer_seq_fifo.sv
// seq_fifo: synchronous show-ahead FIFO holding packed operand triples.
// The head entry is always presented on o_rdata; a pop advances it.
module seq_fifo
  import dp_seq_pkg::*;
#(
  parameter int WIDTH = 3 * DATAWIDTH_DEF,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_wr;
  logic             w_rd;

  // A push into a full FIFO and a pop from an empty one are both ignored
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr];

  // Storage write; contents need no reset since the count gates visibility
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end

endmodule

// File: rtl/dp_operand_sequencer.sv
// dp_operand_sequencer: buffers operand triples, issues them one at a time
// to an attached datapath, waits out its latency and returns (x, z) over a
// valid/ready handshake.
// Optional macro DP_SELF_CHECK_EN: adds a reference model that flags any
// result mismatch on the sticky err output (otherwise err is tied low).
module dp_operand_sequencer
  import dp_seq_pkg::*;
#(
  parameter int DATAWIDTH  = DATAWIDTH_DEF,
  parameter int DEPTH      = 4,
  parameter int DP_LATENCY = 1
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [DATAWIDTH-1:0]   op_a,
  input  logic [DATAWIDTH-1:0]   op_b,
  input  logic [DATAWIDTH-1:0]   op_c,
  output logic [DATAWIDTH-1:0]   dp_a,
  output logic [DATAWIDTH-1:0]   dp_b,
  output logic [DATAWIDTH-1:0]   dp_c,
  input  logic [2*DATAWIDTH-1:0] dp_x,
  input  logic [DATAWIDTH-1:0]   dp_z,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [2*DATAWIDTH-1:0] res_x,
  output logic [DATAWIDTH-1:0]   res_z,
  output logic                   busy,
  output logic                   err
);

  localparam int DW = DATAWIDTH;
  localparam int XW = 2 * DATAWIDTH;
  localparam int CW = (DP_LATENCY < 1) ? 1 : $clog2(DP_LATENCY + 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_capture;
  logic [3*DW-1:0] w_head;
  logic [DW-1:0]   w_ha;
  logic [DW-1:0]   w_hb;
  logic [DW-1:0]   w_hc;

  // ---- stage 0: operand buffering ----
  seq_fifo #(
    .WIDTH (3 * DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (Clk),
    .rst     (Rst),
    .i_push  (op_valid),
    .i_wdata ({op_a, op_b, op_c}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_ha, w_hb, w_hc} = w_head;
  assign op_ready  = !w_full;
  assign busy      = (r_state != IDLE);
  assign w_pop     = (r_state == IDLE) && !w_empty;
  assign w_capture = (r_state == WAIT) && (r_cnt == '0);

  // ---- stage 1: issue to datapath, wait its latency, capture result ----
  // Issue / wait / hold sequencing; dp_* persist until the next pop
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      res_valid <= 1'b0;
      dp_a      <= '0;
      dp_b      <= '0;
      dp_c      <= '0;
      res_x     <= '0;
      res_z     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            dp_a    <= w_ha;
            dp_b    <= w_hb;
            dp_c    <= w_hc;
            r_cnt   <= CW'(DP_LATENCY);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (w_capture) begin
            res_x     <= dp_x;
            res_z     <= dp_z;
            res_valid <= 1'b1;
            r_state   <= HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DP_SELF_CHECK_EN
  logic [DW-1:0] r_chk_d;
  logic [DW-1:0] r_chk_e;
  logic [XW-1:0] r_chk_x;
  logic          r_err;

  // Wrapping sum of two operands
  function automatic logic [DW-1:0] wrap_add(input logic [DW-1:0] p,
                                             input logic [DW-1:0] q);
    return p + q;
  endfunction

  // Full-width product less the zero-extended wrapped sum, modulo 2^XW
  function automatic logic [XW-1:0] exp_x(input logic [DW-1:0] p,
                                          input logic [DW-1:0] q,
                                          input logic [DW-1:0] s);
    logic [XW-1:0] w_prod;
    w_prod = XW'(p) * XW'(q);
    return w_prod - XW'(s);
  endfunction

  // Reference values latched at issue, compared at capture; err is sticky
  always_ff @(posedge Clk) begin
    if (w_pop) begin
      r_chk_d <= wrap_add(w_ha, w_hb);
      r_chk_e <= wrap_add(w_ha, w_hc);
      r_chk_x <= exp_x(w_ha, w_hc, wrap_add(w_ha, w_hb));
    end
    if (Rst) begin
      r_err <= 1'b0;
    end else if (w_capture &&
                 ((dp_x != r_chk_x) || ((dp_z != r_chk_d) && (dp_z != r_chk_e)))) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
